seg_scan_capture: RTL and testbench

//  Receive-side counterpart of our 4-digit multiplexed 7-segment driver: samples DIGIT/DISPLAY scan

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg7_to_sym.sv | 32 +++
 rtl/seg_scan_capture.sv | 190 +++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan capture: active-low segment patterns,
// symbol codes and the capture FSM state encoding.
// Patterns are ordered {g,f,e,d,c,b,a}. A segment is lit when its bit is 0.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_UP    = 7'b1011100;
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;

    localparam logic [3:0] SYM_BLANK   = 4'd12;
    localparam logic [3:0] SYM_ILLEGAL = 4'd13;
    localparam logic [3:0] SYM_UP      = 4'd14;
    localparam logic [3:0] SYM_DOWN    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_to_sym.sv
// Purpose: map an active-low 7-segment pattern to a 4-bit symbol code.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure lookup; unknown patterns decode to SYM_ILLEGAL.
// Ports: seg (pattern {g,f,e,d,c,b,a}), sym (0-9, 12 blank, 13 illegal, 14 up, 15 down).
module seg7_to_sym
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] sym
);

    always_comb begin
        sym = SYM_ILLEGAL;
        case (seg)
            SEG_0:     sym = 4'd0;
            SEG_1:     sym = 4'd1;
            SEG_2:     sym = 4'd2;
            SEG_3:     sym = 4'd3;
            SEG_4:     sym = 4'd4;
            SEG_5:     sym = 4'd5;
            SEG_6:     sym = 4'd6;
            SEG_7:     sym = 4'd7;
            SEG_8:     sym = 4'd8;
            SEG_9:     sym = 4'd9;
            SEG_BLANK: sym = SYM_BLANK;
            SEG_UP:    sym = SYM_UP;
            SEG_DOWN:  sym = SYM_DOWN;
            default:   sym = SYM_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Purpose: rebuild four multiplexed 7-segment digits from sampled DIGIT/DISPLAY scan lines.
// Latency: symbol visible 2 + STABLE_CYC + 1 cycles after a scan line change.
// Backpressure: none; free-running monitor, samples every clk, never stalls the source.
// Ports: clk, rst (async active-low), DIGIT[3:0] / DISPLAY[6:0] (active-low scan inputs),
//        sym0..sym3, value, frame_valid, scan_lost, err; err_cnt[7:0] when
//        SEG_SCAN_ERRCNT_EN is defined (saturating count of err pulses).
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DIGIT,
    input  logic [6:0] DISPLAY,
    output logic [3:0] sym0,
    output logic [3:0] sym1,
    output logic [3:0] sym2,
    output logic [3:0] sym3,
    output logic [6:0] value,
    output logic       frame_valid,
    output logic       scan_lost,
    output logic       err
`ifdef SEG_SCAN_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int          CW     = $clog2(STABLE_CYC + 1);
    localparam logic [20:0] TO_MAX = 21'(TIMEOUT_CYC);

    // Two-flop synchronizer. Reset to the "nothing driven" pattern so the
    // first real scan after reset is seen as a change.
    logic [10:0] sync1, samp, prev;
    logic        changed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            samp  <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {DIGIT, DISPLAY};
            samp  <= sync1;
            prev  <= samp;
        end
    end

    assign changed = (samp != prev);

    // Capture FSM
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (changed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(STABLE_CYC - 1)) begin
                    state_d = ST_ACCEPT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACCEPT: begin
                accept = 1'b1;
                // A change landing in the accept cycle starts a new settle
                // immediately rather than being lost in HOLD.
                if (changed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // During ACCEPT, prev holds the value that was stable for STABLE_CYC samples.
    logic [3:0] dec_sym;
    logic [1:0] dig_idx;
    logic       dig_ok;

    seg7_to_sym u_dec (
        .seg (prev[6:0]),
        .sym (dec_sym)
    );

    always_comb begin
        dig_idx = 2'd0;
        dig_ok  = 1'b1;
        case (prev[10:7])
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: dig_ok  = 1'b0;
        endcase
    end

    // Symbol registers, frame tracking and scan timeout
    logic [3:0]  sym_q [4];
    logic [3:0]  seen_q;
    logic [3:0]  seen_nxt;
    logic [20:0] to_cnt;

    assign seen_nxt = seen_q | (4'b0001 << dig_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) sym_q[i] <= SYM_BLANK;
            seen_q      <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            to_cnt      <= '0;
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (accept) begin
                to_cnt <= '0;
                if (dig_ok) begin
                    sym_q[dig_idx] <= dec_sym;
                    err            <= (dec_sym == SYM_ILLEGAL);
                    if (seen_nxt == 4'b1111) begin
                        frame_valid <= 1'b1;
                        seen_q      <= '0;
                    end else begin
                        seen_q <= seen_nxt;
                    end
                end else begin
                    err <= 1'b1;
                end
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 21'd1;
            end
        end
    end

    assign scan_lost = (to_cnt == TO_MAX);

    assign sym0 = sym_q[0];
    assign sym1 = sym_q[1];
    assign sym2 = sym_q[2];
    assign sym3 = sym_q[3];

    assign value = (sym_q[0] < 4'd10 && sym_q[1] < 4'd10)
                 ? ({3'b0, sym_q[1]} * 7'd10 + {3'b0, sym_q[0]})
                 : 7'd0;

`ifdef SEG_SCAN_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with hand-computed expectations.
// Inputs are driven and outputs checked 3 time units after each rising edge;
// pulse outputs are counted by a falling-edge monitor.
module tb_seg_scan_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic [3:0] sym0, sym1, sym2, sym3;
    logic [6:0] value;
    logic       frame_valid, scan_lost, err;
`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    seg_scan_capture #(
        .STABLE_CYC  (16),
        .TIMEOUT_CYC (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY),
        .sym0        (sym0),
        .sym1        (sym1),
        .sym2        (sym2),
        .sym3        (sym3),
        .value       (value),
        .frame_valid (frame_valid),
        .scan_lost   (scan_lost),
        .err         (err)
`ifdef SEG_SCAN_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hand-written active-low patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PUP   = 7'b1011100;
    localparam logic [6:0] PDOWN = 7'b1100011;
    localparam logic [6:0] PBAD  = 7'b0000001;

    int checks = 0;
    int errors = 0;

    int fv_cnt     = 0;
    int err_pulses = 0;
    int glitch_bad = 0;
    logic mon_en = 1'b0;

    int fv_base;
    int err_base;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (err) err_pulses++;
        if (mon_en && sym0 != 4'd5) glitch_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic scan(input logic [3:0] d, input logic [6:0] s, input int n);
        DIGIT   = d;
        DISPLAY = s;
        tick(n);
    endtask

    initial begin
        rst     = 1'b0;
        DIGIT   = 4'hF;
        DISPLAY = 7'h7F;
        tick(3);

        // Reset state
        check("rst_sym0", 32'(sym0), 32'd12);
        check("rst_sym1", 32'(sym1), 32'd12);
        check("rst_sym2", 32'(sym2), 32'd12);
        check("rst_sym3", 32'(sym3), 32'd12);
        check("rst_value", 32'(value), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_lost", 32'(scan_lost), 32'd0);
        check("rst_err", 32'(err), 32'd0);
`ifdef SEG_SCAN_ERRCNT_EN
        check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b1;
        tick(4);

        // 1: full scan, with exact latency on the first digit
        fv_base  = fv_cnt;
        err_base = err_pulses;
        scan(4'b0111, P2, 18);
        check("lat_before", 32'(sym3), 32'd12);
        tick(1);
        check("lat_after", 32'(sym3), 32'd2);
        tick(45);
        scan(4'b1011, PUP, 64);
        scan(4'b1101, P4, 64);
        check("no_early_frame", 32'(fv_cnt - fv_base), 32'd0);
        scan(4'b1110, P7, 64);
        check("t1_sym3", 32'(sym3), 32'd2);
        check("t1_sym2", 32'(sym2), 32'd14);
        check("t1_sym1", 32'(sym1), 32'd4);
        check("t1_sym0", 32'(sym0), 32'd7);
        check("t1_value", 32'(value), 32'd47);
        check("t1_frames", 32'(fv_cnt - fv_base), 32'd1);
        check("t1_errs", 32'(err_pulses - err_base), 32'd0);

        // 2: glitch shorter than the stability window is ignored
        scan(4'b1110, P5, 64);
        check("t2_sym0_set", 32'(sym0), 32'd5);
        fv_base  = fv_cnt;
        err_base = err_pulses;
        mon_en   = 1'b1;
        scan(4'b1110, P8, 5);
        scan(4'b1110, P5, 64);
        mon_en   = 1'b0;
        tick(1);
        check("t2_glitch_bad", 32'(glitch_bad), 32'd0);
        check("t2_sym0", 32'(sym0), 32'd5);
        check("t2_errs", 32'(err_pulses - err_base), 32'd0);
        check("t2_frames", 32'(fv_cnt - fv_base), 32'd0);

        // 3: non-one-hot DIGIT
        err_base = err_pulses;
        scan(4'b1100, P5, 32);
        check("t3_errs", 32'(err_pulses - err_base), 32'd1);
        check("t3_sym0", 32'(sym0), 32'd5);
        check("t3_sym1", 32'(sym1), 32'd4);
        check("t3_sym2", 32'(sym2), 32'd14);
        check("t3_sym3", 32'(sym3), 32'd2);
`ifdef SEG_SCAN_ERRCNT_EN
        check("t3_errcnt", 32'(err_cnt), 32'd1);
`endif

        // 4: illegal pattern on d1
        err_base = err_pulses;
        scan(4'b1101, PBAD, 32);
        check("t4_sym1", 32'(sym1), 32'd13);
        check("t4_errs", 32'(err_pulses - err_base), 32'd1);
        check("t4_value", 32'(value), 32'd0);
`ifdef SEG_SCAN_ERRCNT_EN
        check("t4_errcnt", 32'(err_cnt), 32'd2);
`endif

        // 5: timeout. Last symbol write was 19 cycles after the d1 drive,
        // so scan_lost rises 256 cycles later, at cycle 275 of that drive.
        tick(242);
        check("t5_lost_before", 32'(scan_lost), 32'd0);
        tick(1);
        check("t5_lost_at", 32'(scan_lost), 32'd1);
        tick(50);
        check("t5_lost_held", 32'(scan_lost), 32'd1);
        check("t5_sym_kept", 32'(sym1), 32'd13);
        scan(4'b1011, P9, 18);
        check("t5_lost_pre", 32'(scan_lost), 32'd1);
        tick(1);
        check("t5_lost_clr", 32'(scan_lost), 32'd0);
        check("t5_sym2", 32'(sym2), 32'd9);
        tick(13);
        fv_base = fv_cnt;
        scan(4'b0111, P1, 32);
        check("t5_frame", 32'(fv_cnt - fv_base), 32'd1);
        check("t5_sym3", 32'(sym3), 32'd1);

        // 6: reset in the middle of a settle after two digits
        scan(4'b1110, P3, 64);
        scan(4'b1101, P6, 64);
        scan(4'b1011, P8, 8);
        rst     = 1'b0;
        DIGIT   = 4'hF;
        DISPLAY = 7'h7F;
        tick(1);
        check("t6_sym0", 32'(sym0), 32'd12);
        check("t6_sym1", 32'(sym1), 32'd12);
        check("t6_sym2", 32'(sym2), 32'd12);
        check("t6_sym3", 32'(sym3), 32'd12);
        check("t6_value", 32'(value), 32'd0);
`ifdef SEG_SCAN_ERRCNT_EN
        check("t6_errcnt", 32'(err_cnt), 32'd0);
`endif
        tick(2);
        rst = 1'b1;
        tick(3);
        fv_base = fv_cnt;
        scan(4'b0111, P0, 64);
        scan(4'b1011, PDOWN, 64);
        scan(4'b1101, P9, 64);
        check("t6_no_partial", 32'(fv_cnt - fv_base), 32'd0);
        scan(4'b1110, P3, 64);
        check("t6_frames", 32'(fv_cnt - fv_base), 32'd1);
        check("t6_value93", 32'(value), 32'd93);
        check("t6_sym3", 32'(sym3), 32'd0);
        check("t6_sym2", 32'(sym2), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
